mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a shared 4:1 mux path. Four requesters
//  compete for one output channel. The block grants one requester at a time and
//  drives the mux select {s1,s0}. It registers the selected data with a valid flag.
//  It sits between the requesters and the downstream consumer of the mux output.
// PARAMETERS
//  DATA_W    8  width of each data input and of dout
//  MAX_HOLD  4  max consecutive grant cycles per requester (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       async reset, active low
//  req         in   4       request per requester, level, held while wanting bus
//  din0..din3  in   DATA_W  requester data; selected by sel
//  gnt         out  4       one-hot grant (registered), 0 when idle
//  sel         out  2       mux select {s1,s0}; 0->din0 .. 3->din3
//  dout        out  DATA_W  registered mux output
//  dout_valid  out  1       dout holds granted data this cycle
// BEHAVIOUR
//  Reset
//  - One clock domain.
//  - rst_n low asynchronously clears all state: gnt=0, sel=0, dout=0,
//    dout_valid=0, ptr=0, cnt=0, state=IDLE.
//  - Asserting reset mid-grant aborts the grant at once. After release the block
//    restarts in IDLE with ptr=0.
//  Priority
//  - ptr[1:0] marks the highest-priority requester.
//  - Winner = first set req[i] scanning i=ptr, ptr+1, ... with mod-4 wrap (3->0).
//  FSM IDLE
//  - gnt=0 and cnt=0.
//  - If any req bit is set at edge N, gnt=onehot(winner), sel=winner and
//    state=BUSY from edge N. The grant is visible in cycle N+1.
//  FSM BUSY
//  - gnt and sel hold, and cnt increments each cycle.
//  - Release happens at an edge where req[sel]==0 or cnt==MAX_HOLD-1.
//  - If both release conditions are true on the same edge, the grant is released
//    once, with no double pointer advance.
//  - On release, ptr=sel+1 mod 4 and the winner is recomputed with the new ptr
//    from the current req.
//  - Winner exists: grant it at the same edge (back-to-back handoff, no idle gap),
//    then cnt=0 and stay BUSY.
//  - The old holder is re-granted only if no other requester is pending.
//  - No winner: gnt=0, cnt=0, state=IDLE.
//  - New requests during BUSY never preempt the current grant.
//  Datapath
//  - Each edge: dout <= din[sel] if state is BUSY, else dout holds its value.
//  - dout_valid <= (state==BUSY).
//  - Latency is 1 cycle from gnt/sel to dout/dout_valid. dout_valid falls one
//    cycle after gnt falls.
//  Invariants and widths
//  - gnt is always zero or one-hot, and sel==index(gnt) whenever gnt!=0.
//  - cnt width is $clog2(MAX_HOLD)+1. cnt never exceeds MAX_HOLD-1.
//  - With MAX_HOLD=1, the grant rotates every cycle among active requesters.
// TESTING
//  1. Run a 2-cycle reset, then req=0 -> gnt=0, sel=0, dout_valid=0 for 5 cycles.
//  2. Set req=4'b0100, din2=8'hA5 and drop req after 3 cycles ->
//     gnt=4'b0100 and sel=2 for 3 cycles. dout=8'hA5 with dout_valid=1 one cycle
//     later. Then the block returns to IDLE.
//  3. Hold req=4'b1111 with MAX_HOLD=4 -> grants 0,1,2,3,0, each exactly 4 cycles.
//     No gnt=0 cycle between grants, and dout tracks din[sel] one cycle late.
//  4. Check wrap. After a grant to 2 is released (ptr=3), set req=4'b0011 ->
//     the next grant is 4'b0001, not 4'b0010.
//  5. Make req[sel] drop on the same edge that cnt hits MAX_HOLD-1, with
//     req=4'b1001 and current=0 -> exactly one handoff to 3. Then ptr=0 after
//     the grant to 3 ends.
//  6. Pulse rst_n low mid-BUSY between edges -> gnt, sel, dout and dout_valid
//     go to 0 immediately. After release, the first grant follows ptr=0 order.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux path, with a registered data output.
// Latency: a request seen at edge N is granted in cycle N+1; dout/dout_valid follow gnt/sel one cycle later.
// Backpressure: none downstream; a holder keeps the grant until it drops req or uses MAX_HOLD cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   req[3:0]            level requests, held while a requester wants the path
//   din0..din3          requester data, selected by sel
//   gnt[3:0]            registered one-hot grant, zero when idle
//   sel[1:0]            mux select {s1,s0}; index of the granted requester
//   dout, dout_valid    registered mux output and its qualifier
module mux4_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    localparam int              CNT_W    = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;

    // Returns {found, index} of the first set request scanning from start
    // upward with mod-4 wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] pick_idle;
    logic [2:0] pick_rel;
    logic [1:0] rel_ptr;
    logic       hold_done;
    logic       rel;

    // On release the pointer moves just past the current holder, so the
    // holder itself is scanned last and only wins when nobody else waits.
    assign rel_ptr   = sel_q + 2'd1;
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_rel  = rr_pick(req, rel_ptr);
    assign hold_done = (cnt_q == CNT_LAST);
    // Either condition alone or both together produce a single release.
    assign rel       = !req[sel_q] || hold_done;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                gnt_d = 4'b0000;
                if (pick_idle[2]) begin
                    gnt_d   = 4'b0001 << pick_idle[1:0];
                    sel_d   = pick_idle[1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_d = rel_ptr;
                    cnt_d = '0;
                    if (pick_rel[2]) begin
                        // Back-to-back handoff: the new holder takes the
                        // path on the same edge, no idle cycle in between.
                        gnt_d = 4'b0001 << pick_rel[1:0];
                        sel_d = pick_rel[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    logic [DATA_W-1:0] mux_dat;

    always_comb begin
        mux_dat = din0;
        case (sel_q)
            2'd0:    mux_dat = din0;
            2'd1:    mux_dat = din1;
            2'd2:    mux_dat = din2;
            2'd3:    mux_dat = din3;
            default: mux_dat = din0;
        endcase
    end

    // The output register captures the mux only while a grant is live;
    // otherwise it keeps the last granted word.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = (state_q == BUSY);
        if (state_q == BUSY) begin
            dout_d = mux_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            cnt_q        <= '0;
            gnt_q        <= 4'b0000;
            sel_q        <= 2'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = 4'b0000;
    logic [DATA_W-1:0] din0 = '0;
    logic [DATA_W-1:0] din1 = '0;
    logic [DATA_W-1:0] din2 = '0;
    logic [DATA_W-1:0] din3 = '0;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] din_of(input int i);
        case (i)
            0:       return din0;
            1:       return din1;
            2:       return din2;
            default: return din3;
        endcase
    endfunction

    // Reference model: who holds the path, how many cycles it has held it,
    // and where the round-robin scan starts next.
    int                m_holder = -1;
    int                m_run    = 0;
    int                m_ptr    = 0;
    logic [DATA_W-1:0] m_dout   = '0;
    logic              m_valid  = 1'b0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder = -1;
            m_run    = 0;
            m_ptr    = 0;
            m_dout   = '0;
            m_valid  = 1'b0;
        end else begin
            m_valid = (m_holder >= 0);
            if (m_holder >= 0) m_dout = din_of(m_holder);
            if (m_holder < 0) begin
                m_holder = pick(req, m_ptr);
                m_run    = (m_holder >= 0) ? 1 : 0;
            end else if (!req[m_holder] || m_run == MAX_HOLD) begin
                m_ptr    = (m_holder + 1) % 4;
                m_holder = pick(req, m_ptr);
                m_run    = (m_holder >= 0) ? 1 : 0;
            end else begin
                m_run++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt", gnt, (m_holder < 0) ? 0 : (1 << m_holder));
            if (m_holder >= 0) chk("model_sel", sel, m_holder);
            chk("model_dout_valid", dout_valid, m_valid);
            chk("model_dout", dout, m_dout);
            chk("gnt_onehot", ($countones(gnt) <= 1), 1);
        end
    end

    initial begin
        din0 = 8'h10;
        din1 = 8'h21;
        din2 = 8'h33;
        din3 = 8'h4C;
        rst_n = 1'b0;
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_valid", dout_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_gnt", gnt, 0);
            chk("idle_sel", sel, 0);
            chk("idle_valid", dout_valid, 0);
            chk("idle_dout", dout, 0);
        end

        // Single requester 2 for three cycles.
        din2 = 8'hA5;
        req  = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("single_gnt", gnt, 4'b0100);
            chk("single_sel", sel, 2);
            if (k == 0) begin
                chk("single_valid_lag", dout_valid, 0);
            end else begin
                chk("single_valid", dout_valid, 1);
                chk("single_dout", dout, 8'hA5);
            end
        end
        req = 4'b0000;
        @(negedge clk);
        chk("single_release_gnt", gnt, 0);
        chk("single_tail_valid", dout_valid, 1);
        chk("single_tail_dout", dout, 8'hA5);
        @(negedge clk);
        chk("single_idle_valid", dout_valid, 0);
        chk("single_idle_dout_hold", dout, 8'hA5);

        // Pointer is 3 after the grant to 2: scan 3,0,1 picks 0.
        req = 4'b0011;
        @(negedge clk);
        chk("wrap_gnt", gnt, 4'b0001);

        // Asynchronous reset between edges while busy.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_sel", sel, 0);
        chk("arst_dout", dout, 0);
        chk("arst_valid", dout_valid, 0);
        req = 4'b1111;
        #1 rst_n = 1'b1;

        // All requesting: 0,1,2,3,0 for MAX_HOLD cycles each, no gaps.
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                @(negedge clk);
                chk("rr_gnt", gnt, 1 << (g % 4));
                chk("rr_sel", sel, g % 4);
                if (g == 0 && c == 0) begin
                    chk("rr_first_valid", dout_valid, 0);
                end else if (c == 0) begin
                    chk("rr_handoff_dout", dout, din_of((g + 3) % 4));
                end else begin
                    chk("rr_dout", dout, din_of(g % 4));
                end
                // Second grant to 0: requester 0 drops exactly at its last
                // allowed cycle, with only 3 else pending.
                if (g == 4 && c == 0) req = 4'b1001;
                if (g == 4 && c == MAX_HOLD - 1) req = 4'b1000;
            end
        end

        // Single handoff to 3, which then holds its full slot.
        for (int c = 0; c < MAX_HOLD; c++) begin
            @(negedge clk);
            chk("both_rel_gnt", gnt, 4'b1000);
            chk("both_rel_sel", sel, 3);
            if (c == MAX_HOLD - 1) req = 4'b0000;
        end
        @(negedge clk);
        chk("after3_idle_gnt", gnt, 0);
        req = 4'b1111;
        @(negedge clk);
        chk("after3_ptr0_gnt", gnt, 4'b0001);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Lone requester keeps being re-granted across hold boundaries.
        req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("lone_gnt", gnt, 4'b0010);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("final_gnt", gnt, 0);
        chk("final_valid", dout_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
